// File: rtl/pipelined_shifter.sv
// Pipelined N-bit shifter, one register stage per shift level, valid/ready on both sides.
// Define SHIFTER_ROTATE_EN to build rotate-left for mode 11; otherwise mode 11 is logical left. Requires logN >= 2.
module pipelined_shifter #(
  parameter int N    = 8,
  parameter int logN = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_data,
  input  logic [logN-1:0] in_amt,
  input  logic [1:0]      in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_data,
  output logic            out_zero
);

  localparam int S = logN;

  logic [N-1:0] data_q [S];
  logic [S-1:0] valid_q;
  // side-band for stages that still feed a later stage; amount is pre-shifted so bit 0 is always next
  logic [S-1:0] amt_q  [S-1];
  logic [1:0]   mode_q [S-1];
  logic [S-2:0] sign_q;

  logic [N-1:0] src_data [S];
  logic [N-1:0] nxt_data [S];
  logic [S-1:0] src_amt  [S];
  logic [1:0]   src_mode [S];
  logic [S-1:0] src_sign;
  logic [S-1:0] src_valid;
  logic         adv;

  function automatic logic [N-1:0] shift_stage(input logic [N-1:0] w, input logic [1:0] mode,
                                               input logic sign, input int lvl);
    logic [N-1:0] fill;
    logic [N-1:0] res;
    fill = sign ? ~({N{1'b1}} >> (1 << lvl)) : '0;
    case (mode)
      2'b01:   res = w >> (1 << lvl);
      2'b10:   res = (w >> (1 << lvl)) | fill;
`ifdef SHIFTER_ROTATE_EN
      2'b11:   res = (w << (1 << lvl)) | (w >> (N - (1 << lvl)));
`endif
      default: res = w << (1 << lvl);
    endcase
    return res;
  endfunction

  always_comb begin
    src_data[0]  = in_data;
    src_amt[0]   = in_amt;
    src_mode[0]  = in_mode;
    src_sign[0]  = in_data[N-1];
    src_valid[0] = in_valid;
    for (int j = 1; j < S; j++) begin
      src_data[j]  = data_q[j-1];
      src_amt[j]   = amt_q[j-1];
      src_mode[j]  = mode_q[j-1];
      src_sign[j]  = sign_q[j-1];
      src_valid[j] = valid_q[j-1];
    end
    for (int j = 0; j < S; j++) begin
      nxt_data[j] = src_amt[j][0] ? shift_stage(src_data[j], src_mode[j], src_sign[j], j)
                                  : src_data[j];
    end
  end

  assign out_valid = valid_q[S-1];
  assign out_data  = data_q[S-1];
  assign out_zero  = (data_q[S-1] == '0);
  // whole pipe moves or holds as one; no bubble collapse
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      sign_q  <= '0;
      for (int j = 0; j < S; j++) data_q[j] <= '0;
      for (int j = 0; j < S - 1; j++) begin
        amt_q[j]  <= '0;
        mode_q[j] <= '0;
      end
    end else if (adv) begin
      valid_q <= src_valid;
      for (int j = 0; j < S; j++) data_q[j] <= nxt_data[j];
      for (int j = 0; j < S - 1; j++) begin
        amt_q[j]  <= src_amt[j] >> 1;
        mode_q[j] <= src_mode[j];
        sign_q[j] <= src_sign[j];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter: directed cases plus random traffic against a queue model.
// Honours SHIFTER_ROTATE_EN the same way as the design.
module tb_pipelined_shifter;

  localparam int N = 8;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [S-1:0] in_amt;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_zero;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [N-1:0] res;
    int           stamp;
  } item_t;

  item_t exp_q[$];
  int    adv_total = 0;

  pipelined_shifter #(.N(N), .logN(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference: apply the whole shift amount at once with integer arithmetic
  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] d, input int amt, input logic [1:0] mode);
    int v;
    int s;
    case (mode)
      2'd1: v = int'(d) / (1 << amt);
      2'd2: begin
        s = d[N-1] ? int'(d) - (1 << N) : int'(d);
        v = s >>> amt;
      end
`ifdef SHIFTER_ROTATE_EN
      2'd3: v = (int'(d) * (1 << amt) + int'(d) / (1 << (N - amt))) % (1 << N);
`endif
      default: v = (int'(d) * (1 << amt)) % (1 << N);
    endcase
    return v[N-1:0];
  endfunction

  // model: a beat becomes visible once the pipe has advanced S times since it was accepted
  always @(negedge clk) begin
    logic mv;
    logic adv;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      mv = (exp_q.size() > 0) && ((adv_total - exp_q[0].stamp) >= S);
      check("out_valid", out_valid, mv);
      check("in_ready", in_ready, !mv || out_ready);
      if (mv) begin
        check("out_data", out_data, exp_q[0].res);
        check("out_zero", out_zero, exp_q[0].res == 0);
      end
      adv = !mv || out_ready;
      if (mv && out_ready) void'(exp_q.pop_front());
      if (adv) begin
        adv_total++;
        if (in_valid) exp_q.push_back('{ref_shift(in_data, int'(in_amt), in_mode), adv_total - 1});
      end
    end
  end

  task automatic send(input logic [N-1:0] d, input logic [S-1:0] a, input logic [1:0] m);
    logic acc;
    int   tries;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_mode  = m;
    tries    = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!acc && tries < 50);
    check("accept", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data  = N'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic directed(input string tag, input logic [N-1:0] d, input logic [S-1:0] a,
                          input logic [1:0] m, input logic [N-1:0] exp);
    send(d, a, m);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_early"}, out_valid, 1'b0);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, exp);
    check({tag, "_zero"}, out_zero, exp == 0);
    idle(2);
  endtask

  initial begin
    logic [N-1:0] rot_exp;
    int           t;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; out_ready = 1'b1;

    @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 0);
    check("rst_zero", out_zero, 1'b1);
    check("rst_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_valid", out_valid, 1'b0);
      check("idle_data", out_data, 0);
      check("idle_zero", out_zero, 1'b1);
      check("idle_ready", in_ready, 1'b1);
    end
    @(posedge clk);
    #1;

`ifdef SHIFTER_ROTATE_EN
    rot_exp = 8'h8D;
`else
    rot_exp = 8'h88;
`endif
    directed("mode00", 8'hB1, 3'd3, 2'b00, 8'h88);
    directed("mode01", 8'hB1, 3'd3, 2'b01, 8'h16);
    directed("mode10", 8'hB1, 3'd3, 2'b10, 8'hF6);
    directed("mode11", 8'hB1, 3'd3, 2'b11, rot_exp);

    directed("lsl7", 8'h01, 3'd7, 2'b00, 8'h80);
    directed("asr7", 8'h80, 3'd7, 2'b10, 8'hFF);
    directed("lsr1", 8'h01, 3'd1, 2'b01, 8'h00);
    directed("amt0_asr", 8'hC3, 3'd0, 2'b10, 8'hC3);
    directed("amt0_rol", 8'h5A, 3'd0, 2'b11, 8'h5A);

    for (int i = 0; i < 16; i++) send(N'(i), S'(i % 8), 2'b00);
    idle(6);
    check("stream_drained", exp_q.size(), 0);

    out_ready = 1'b0;
    fork
      begin
        send(8'h3C, 3'd2, 2'b00);
        for (int i = 1; i < 6; i++) send(N'($urandom), S'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        in_valid = 1'b0;
      end
      begin
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!out_valid && t < 20);
        check("bp_first_valid", out_valid, 1'b1);
        repeat (4) begin
          check("bp_ready_low", in_ready, 1'b0);
          check("bp_hold", out_data, 8'hF0);
          @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(8);
    check("bp_drained", exp_q.size(), 0);

    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = N'($urandom);
      in_amt    = S'($urandom_range(0, 7));
      in_mode   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    idle(8);
    check("rand_drained", exp_q.size(), 0);

    send(8'h11, 3'd1, 2'b00);
    send(8'h22, 3'd2, 2'b01);
    send(8'h33, 3'd3, 2'b10);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("flush_valid", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    directed("post_rst", 8'h5A, 3'd4, 2'b01, 8'h05);
    idle(4);
    check("final_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
